instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_VECTOR, default 64'h0, PC value loaded on reset.
REQ-002 Parameter FQ_DEPTH, default 2, fetch-queue entries; legal range 2..8.
REQ-003 Clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Redirect  in  1  taken-branch/jump pulse from PC logic.
REQ-006 RedirectPC  in  64  redirect target (NextPC from PC logic).
REQ-007 ImemReqValid  out  1  fetch request valid.
REQ-008 ImemReqReady  in  1  instruction memory accepts request.
REQ-009 ImemReqAddr  out  64  fetch address, bits [1:0] always 0.
REQ-010 ImemRspValid  in  1  response valid; responses return in request order, no backpressure.
REQ-011 ImemRspData  in  32  instruction word.
REQ-012 DecValid  out  1  instruction available to decode.
REQ-013 DecReady  in  1  decode accepts instruction.
REQ-014 DecInstr  out  32  instruction at queue head.
REQ-015 DecPC  out  64  address of DecInstr.
REQ-016 StallCount  out  32  decode-starved cycle count; present only with IF_STALL_COUNT_EN.

Function
REQ-017 Request handshake = ImemReqValid & ImemReqReady; decode handshake = DecValid & DecReady.
REQ-018 ImemReqValid SHALL be 1 iff Redirect=0 and (inflight + queue occupancy) < FQ_DEPTH; ImemReqAddr = FetchPC.
REQ-019 On request handshake without Redirect: FetchPC <= FetchPC + 4 (modulo 2^64), inflight increments, request PC pushed to an in-order PC tag FIFO.
REQ-020 ImemReqValid/ImemReqAddr SHALL stay stable until handshake unless Redirect is asserted.
REQ-021 Accepted response (not dropped) SHALL be written to fetch queue with its tagged PC; DecValid rises the cycle after (latency 1, no bypass).
REQ-022 DecValid = queue non-empty; DecInstr/DecPC = head entry; head pops on decode handshake.
REQ-023 Simultaneous push and pop SHALL both occur; queue never overflows because of REQ-018 credit rule.
REQ-024 Redirect: FetchPC <= {RedirectPC[63:2],2'b00}; queue flushed; DecValid=0 next cycle; DropCount <= inflight (after including any same-cycle response/handshake).
REQ-025 While DropCount > 0, each response SHALL decrement DropCount and inflight and be discarded.
REQ-026 Redirect in same cycle as response: that response SHALL be discarded.
REQ-027 Redirect in same cycle as decode handshake: pop is void; queue empty next cycle.
REQ-028 Back-to-back Redirects: last one wins; DropCount tracks all inflight requests.
REQ-029 Response with inflight=0 is a protocol error; SHALL be ignored.

Reset
REQ-030 Rst_n low: FetchPC=RESET_VECTOR, queue empty, inflight=0, DropCount=0, ImemReqValid=0, DecValid=0, StallCount=0.
REQ-031 First request SHALL issue in the first cycle after Rst_n deasserts.
REQ-032 Reset mid-operation discards all in-flight and queued instructions.

Configuration
REQ-033 Macro IF_STALL_COUNT_EN defined: StallCount port exists, increments (saturating at 2^32-1) each cycle DecValid=0 and Rst_n high; undefined: port and counter absent, no other behaviour change.

Structure
REQ-034 Shared package holds XLEN=64, INSTR_W=32, PC_STEP=4, and fetch-queue entry typedef {pc, instr}.
REQ-035 Sub-module fetch_queue: synchronous FIFO with flush, push, pop, empty, count.

Verification
REQ-036 Reset release, ImemReqReady=1, 1-cycle response latency -> addresses 0,4,8,...; DecPC follows in order.
REQ-037 DecReady=0 for 10 cycles -> exactly FQ_DEPTH requests outstanding/queued, ImemReqValid=0, no data lost.
REQ-038 Redirect to 64'h1003 with 2 in flight -> next ImemReqAddr 64'h1000, both old responses dropped, first DecPC 64'h1000.
REQ-039 Redirect coincident with response and decode handshake -> neither old instruction reaches decode.
REQ-040 FetchPC 64'hFFFF_FFFF_FFFF_FFFC handshake -> next ImemReqAddr 64'h0.
REQ-041 With IF_STALL_COUNT_EN, ImemReqReady=0 for 5 cycles after reset -> StallCount>=5.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN       - address / PC width
//   INSTR_W    - instruction word width
//   PC_STEP    - sequential fetch increment
//   fqEntry_t  - fetch-queue entry {pc, instr}
package instr_fetch_pkg;
    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fqEntry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO with flush.
// Ports:
//   Clk, Rst_n         clock, async active-low reset
//   Flush              empties the FIFO (dominates push/pop)
//   Push, PushData     write side (ignored when full)
//   Pop, PopData       read side; PopData is the head entry (ignored when empty)
//   Empty, Count       status
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Flush,
    input  logic             Push,
    input  logic [W-1:0]     PushData,
    input  logic             Pop,
    output logic [W-1:0]     PopData,
    output logic             Empty,
    output logic [CNT_W-1:0] Count
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic [CNT_W-1:0] cnt;
    logic             full, doPush, doPop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign Empty   = (cnt == '0);
    assign Count   = cnt;
    assign full    = (cnt == CNT_W'(DEPTH));
    assign doPush  = Push & ~full & ~Flush;
    assign doPop   = Pop & ~Empty & ~Flush;
    assign PopData = mem[rdPtr];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else if (Flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by cnt.
    always_ff @(posedge Clk) begin
        if (doPush) mem[wrPtr] <= PushData;
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited instruction fetch front end.
// Issues sequential fetches to instruction memory, tags each request with its
// PC, queues returning words for decode, and discards stale responses after a
// redirect.
// Ports:
//   Clk, Rst_n                      clock, async active-low reset
//   Redirect, RedirectPC            taken-branch/jump pulse and target
//   ImemReqValid/Ready/Addr         fetch request channel
//   ImemRspValid/Data               in-order response channel, no backpressure
//   DecValid/Ready, DecInstr/DecPC  decode channel (fetch-queue head)
//   StallCount                      decode-starved cycles, only when the
//                                   IF_STALL_COUNT_EN macro is defined
module instr_fetch import instr_fetch_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0,
    parameter int              FQ_DEPTH     = 2
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Redirect,
    input  logic [XLEN-1:0]    RedirectPC,
    output logic               ImemReqValid,
    input  logic               ImemReqReady,
    output logic [XLEN-1:0]    ImemReqAddr,
    input  logic               ImemRspValid,
    input  logic [INSTR_W-1:0] ImemRspData,
    output logic               DecValid,
    input  logic               DecReady,
    output logic [INSTR_W-1:0] DecInstr,
    output logic [XLEN-1:0]    DecPC
`ifdef IF_STALL_COUNT_EN
   ,output logic [31:0]        StallCount
`endif
);
    localparam int CNT_W = $clog2(FQ_DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~64'h3;

    logic [XLEN-1:0]  fetchPC, redirTgt, tagPC;
    logic [CNT_W-1:0] dropCount, tagCount, fqCount;
    logic [CNT_W:0]   inflightNow, occupancy;
    logic             tagEmpty, fqEmpty;
    logic             reqHs, rspFire, dropping, rspAccept, decPop;
    logic [$bits(fqEntry_t)-1:0] fqPopData;
    fqEntry_t         fqIn, fqHead;

    assign redirTgt = RedirectPC & ALIGN_MASK;

    // In-flight requests = ones awaiting a tag pop plus ones marked for drop.
    assign inflightNow = {1'b0, dropCount} + {1'b0, tagCount};
    assign occupancy   = inflightNow + {1'b0, fqCount};

    // Gated by Rst_n so the request is quiet during reset yet can fire on the
    // first edge after release.
    assign ImemReqValid = Rst_n & ~Redirect & (occupancy < (CNT_W+1)'(FQ_DEPTH));
    assign ImemReqAddr  = fetchPC;
    assign reqHs        = ImemReqValid & ImemReqReady;

    // A response with nothing in flight is a protocol error and is ignored.
    assign rspFire   = ImemRspValid & (inflightNow != '0);
    assign dropping  = (dropCount != '0);
    assign rspAccept = rspFire & ~dropping & ~Redirect;
    assign decPop    = DecValid & DecReady & ~Redirect;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetchPC   <= RESET_VECTOR & ALIGN_MASK;
            dropCount <= '0;
        end else begin
            if (Redirect)   fetchPC <= redirTgt;
            else if (reqHs) fetchPC <= fetchPC + PC_STEP;

            // Everything still outstanding after this cycle's response is stale.
            if (Redirect)
                dropCount <= CNT_W'(inflightNow - (CNT_W+1)'(rspFire));
            else if (rspFire & dropping)
                dropCount <= dropCount - CNT_W'(1);
        end
    end

    // PC tags for undropped in-flight requests; flushed on redirect because
    // every such request becomes a drop.
    fetch_queue #(.DEPTH(FQ_DEPTH), .W(XLEN)) u_tagFifo (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Flush    (Redirect),
        .Push     (reqHs),
        .PushData (fetchPC),
        .Pop      (rspAccept),
        .PopData  (tagPC),
        .Empty    (tagEmpty),
        .Count    (tagCount)
    );

    assign fqIn = '{pc: tagPC, instr: ImemRspData};

    fetch_queue #(.DEPTH(FQ_DEPTH), .W($bits(fqEntry_t))) u_fetchQueue (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Flush    (Redirect),
        .Push     (rspAccept),
        .PushData (fqIn),
        .Pop      (decPop),
        .PopData  (fqPopData),
        .Empty    (fqEmpty),
        .Count    (fqCount)
    );

    assign fqHead   = fqPopData;
    assign DecValid = ~fqEmpty;
    assign DecInstr = fqHead.instr;
    assign DecPC    = fqHead.pc;

`ifdef IF_STALL_COUNT_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            StallCount <= '0;
        else if (!DecValid && (StallCount != '1))
            StallCount <= StallCount + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import instr_fetch_pkg::*;
    localparam int FQ_DEPTH = 2;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic               Rst_n, Redirect, ImemReqValid, ImemReqReady, ImemRspValid;
    logic               DecValid, DecReady;
    logic [XLEN-1:0]    RedirectPC, ImemReqAddr, DecPC;
    logic [INSTR_W-1:0] ImemRspData, DecInstr;
`ifdef IF_STALL_COUNT_EN
    logic [31:0]        StallCount;
`endif

    instr_fetch #(.RESET_VECTOR(64'h0), .FQ_DEPTH(FQ_DEPTH)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemReqAddr(ImemReqAddr),
        .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
        .DecValid(DecValid), .DecReady(DecReady), .DecInstr(DecInstr), .DecPC(DecPC)
`ifdef IF_STALL_COUNT_EN
       ,.StallCount(StallCount)
`endif
    );

    int checks = 0, failures = 0;
    logic [63:0] sbQ[$];   // requested PCs expected at decode, in order
    logic [63:0] memQ[$];  // requests awaiting a memory response
    bit rspHold = 0, spurious = 0;
    logic sReqValid, sDecValid, sReqHs;
    logic [63:0] sReqAddr, sDecPC;

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // One clock: sample/score at negedge, then model memory after posedge.
    task automatic tick();
        logic [63:0] e;
        @(negedge Clk);
        sReqValid = ImemReqValid; sReqAddr = ImemReqAddr;
        sDecValid = DecValid;     sDecPC   = DecPC;
        sReqHs    = ImemReqValid && ImemReqReady;
        if (Redirect) sbQ.delete();
        else if (DecValid && DecReady) begin
            if (sbQ.size() == 0) failNow("dec_unexpected");
            else begin
                e = sbQ.pop_front();
                chk("dec_pc", DecPC, e);
                chk("dec_instr", {32'h0, DecInstr}, {32'h0, memWord(e)});
            end
        end
        if (sReqHs) begin
            chk("addr_align", {62'h0, ImemReqAddr[1:0]}, 64'h0);
            sbQ.push_back(ImemReqAddr);
            memQ.push_back(ImemReqAddr);
        end
        @(posedge Clk);
        #1;
        if (!rspHold && memQ.size() > 0) begin
            ImemRspValid = 1'b1;
            ImemRspData  = memWord(memQ.pop_front());
        end else if (spurious) begin
            ImemRspValid = 1'b1;
            ImemRspData  = 32'hDEAD_BEEF;
        end else begin
            ImemRspValid = 1'b0;
        end
    endtask

    task automatic waitReq(input string name, output logic [63:0] a);
        bit got = 0;
        a = 'x;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (sReqHs) begin got = 1; a = sReqAddr; end
        end
        if (!got) failNow({name, "_timeout"});
    endtask

    task automatic waitDec(input string name, output logic [63:0] pc);
        bit got = 0;
        pc = 'x;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (sDecValid && DecReady) begin got = 1; pc = sDecPC; end
        end
        if (!got) failNow({name, "_timeout"});
    endtask

    task automatic drain(input string name);
        ImemReqReady = 1'b0;
        DecReady     = 1'b1;
        for (int i = 0; i < 30 && (sbQ.size() > 0 || memQ.size() > 0); i++) tick();
        chk(name, 64'(sbQ.size()), 64'h0);
    endtask

    typedef struct {
        bit          reqRdy, decRdy;
        bit          expReqValid;
        logic [63:0] expReqAddr;
        bit          expDecValid;
        logic [63:0] expDecPC;
    } vec_t;
    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        bit found;
        // Startup stream, depth 2, 1-cycle memory latency.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 64'h4,  1'b0, 64'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h8,  1'b1, 64'h4};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 64'hC,  1'b0, 64'h0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 64'h0,  1'b1, 64'h8};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 64'h10, 1'b1, 64'hC};

        Rst_n = 0; Redirect = 0; RedirectPC = '0; ImemReqReady = 1;
        ImemRspValid = 0; ImemRspData = '0; DecReady = 1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_reqvalid", {63'h0, ImemReqValid}, 64'h0);
        chk("rst_decvalid", {63'h0, DecValid}, 64'h0);
        chk("rst_addr", ImemReqAddr, 64'h0);
`ifdef IF_STALL_COUNT_EN
        chk("rst_stall", {32'h0, StallCount}, 64'h0);
`endif
        @(posedge Clk);
        #1 Rst_n = 1;

        for (int i = 0; i < 7; i++) begin
            ImemReqReady = vecs[i].reqRdy;
            DecReady     = vecs[i].decRdy;
            tick();
            chk($sformatf("v%0d_reqvalid", i), {63'h0, sReqValid}, {63'h0, vecs[i].expReqValid});
            if (vecs[i].expReqValid) chk($sformatf("v%0d_addr", i), sReqAddr, vecs[i].expReqAddr);
            chk($sformatf("v%0d_decvalid", i), {63'h0, sDecValid}, {63'h0, vecs[i].expDecValid});
            if (vecs[i].expDecValid) chk($sformatf("v%0d_decpc", i), sDecPC, vecs[i].expDecPC);
        end

        // Decode stall: credit fills, then nothing more is requested.
        DecReady = 0;
        repeat (10) tick();
        chk("stall_reqvalid", {63'h0, sReqValid}, 64'h0);
        chk("stall_decvalid", {63'h0, sDecValid}, 64'h1);
        chk("stall_outstanding", 64'(sbQ.size()), 64'(FQ_DEPTH));
        drain("stall_drain");

        // Redirect with two requests held in flight.
        rspHold = 1; ImemReqReady = 1;
        tick(); tick();
        chk("hold_inflight", 64'(memQ.size()), 64'h2);
        Redirect = 1; RedirectPC = 64'h1003;
        tick();
        chk("redir_reqvalid", {63'h0, sReqValid}, 64'h0);
        Redirect = 0; rspHold = 0;
        waitReq("redir_req", a);
        chk("redir_addr", a, 64'h1000);
        waitDec("redir_dec", a);
        chk("redir_decpc", a, 64'h1000);

        // Redirect coincident with a response and a decode handshake.
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (DecValid && ImemRspValid) found = 1;
        end
        if (!found) failNow("coinc_setup_timeout");
        Redirect = 1; RedirectPC = 64'h2000;
        tick();
        Redirect = 0;
        tick();
        chk("coinc_decvalid", {63'h0, sDecValid}, 64'h0);
        waitDec("coinc_dec", a);
        chk("coinc_decpc", a, 64'h2000);

        // PC wrap at the top of the address space.
        Redirect = 1; RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        Redirect = 0;
        waitReq("wrap_req0", a);
        chk("wrap_addr0", a, 64'hFFFF_FFFF_FFFF_FFFC);
        waitReq("wrap_req1", a);
        chk("wrap_addr1", a, 64'h0);
        drain("wrap_drain");

        // Mid-operation reset, spurious response, stall counting.
        ImemReqReady = 1;
        repeat (3) tick();
        Rst_n = 0;
        sbQ.delete(); memQ.delete(); ImemRspValid = 0;
        @(negedge Clk);
        chk("rst2_reqvalid", {63'h0, ImemReqValid}, 64'h0);
        chk("rst2_decvalid", {63'h0, DecValid}, 64'h0);
        @(posedge Clk);
        #1 Rst_n = 1; ImemReqReady = 0; spurious = 1;
        tick();
        spurious = 0;
        repeat (4) tick();
        chk("spurious_decvalid", {63'h0, DecValid}, 64'h0);
`ifdef IF_STALL_COUNT_EN
        chk("stall_count_ge5", {63'h0, StallCount >= 32'd5}, 64'h1);
`endif
        ImemReqReady = 1;
        waitReq("rst2_req", a);
        chk("rst2_addr", a, 64'h0);
        drain("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
